// File: rtl/logic_result_stage_if.sv
// logic_result_stage_if
//   Handshake and data bundle between an upstream logic unit, the
//   logic_result_stage queue and its downstream consumer.
//
//   Upstream side : Xor/And/Or/Nor (4b candidate results), sel (2b),
//                   in_valid -> ; <- in_ready
//   Downstream side: Out (4b), zero, parity, out_valid, count (2b) -> ;
//                   <- out_ready
//
//   modport slave  : view taken by logic_result_stage
//   modport master : view taken by the environment driving the stage
interface logic_result_stage_if;
  logic [3:0] Xor;
  logic [3:0] And;
  logic [3:0] Or;
  logic [3:0] Nor;
  logic [1:0] sel;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] Out;
  logic       zero;
  logic       parity;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] count;

  modport slave (
    input  Xor, And, Or, Nor, sel, in_valid, out_ready,
    output in_ready, Out, zero, parity, out_valid, count
  );

  modport master (
    output Xor, And, Or, Nor, sel, in_valid, out_ready,
    input  in_ready, Out, zero, parity, out_valid, count
  );
endinterface

// File: rtl/logic_result_stage.sv
// logic_result_stage
//   Selects one of four upstream logic results by sel and holds it in a
//   2-entry in-order queue with one cycle of latency. Head entry drives
//   Out together with zero / parity flags.
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous, active-high reset (clears occupancy only)
//     bus  - logic_result_stage_if.slave:
//              Xor/And/Or/Nor, sel, in_valid  (in)  upstream offer
//              in_ready                        (out) count != 2
//              Out, zero, parity, out_valid    (out) head entry
//              out_ready                       (in)  downstream pop
//              count                           (out) entries held 0..2
//
//   Build option: LOGIC_STAGE_FLAGS_EN
//     defined   - zero/parity computed at push time, stored per entry
//     undefined - no flag storage, zero and parity tied low
module logic_result_stage (
  input  logic                  clk,
  input  logic                  rst,
  logic_result_stage_if.slave   bus
);

  localparam int DATA_W = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              push;
  logic              pop;
  logic              wr_head;
  logic              wr_tail;
  logic              shift;
  logic              vld_p1;
  logic [DATA_W-1:0] sel_res_p0;
  logic [DATA_W-1:0] res_p1 [2];

  function automatic logic [DATA_W-1:0] mux_res(
    input logic [1:0]        s,
    input logic [DATA_W-1:0] x,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] o,
    input logic [DATA_W-1:0] n
  );
    logic [DATA_W-1:0] r;
    case (s)
      2'b00:   r = x;
      2'b01:   r = a;
      2'b10:   r = o;
      default: r = n;
    endcase
    return r;
  endfunction

  // Stage p0: select the candidate result from the upstream unit
  assign sel_res_p0 = mux_res(bus.sel, bus.Xor, bus.And, bus.Or, bus.Nor);

  // Handshakes use only registered occupancy, so in_ready never depends
  // on out_ready and there is no input-to-output combinational path.
  assign push = bus.in_valid && (state != TWO);
  assign pop  = (state != EMPTY) && bus.out_ready;

  always_comb begin
    state_nxt = state;
    wr_head   = 1'b0;
    wr_tail   = 1'b0;
    shift     = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          state_nxt = ONE;
          wr_head   = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          // Head leaves while the new entry replaces it in place
          wr_head = 1'b1;
        end else if (push) begin
          state_nxt = TWO;
          wr_tail   = 1'b1;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_nxt = ONE;
          shift     = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Stage p1: queue storage; slot 0 is always the head. Data is not
  // reset -- occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (wr_head) begin
      res_p1[0] <= sel_res_p0;
    end else if (shift) begin
      res_p1[0] <= res_p1[1];
    end
    if (wr_tail) begin
      res_p1[1] <= sel_res_p0;
    end
  end

  assign vld_p1        = (state != EMPTY);
  assign bus.out_valid = vld_p1;
  assign bus.in_ready  = (state != TWO);
  assign bus.count     = 2'(state);
  // Gated so an empty queue (including right after reset) shows 0000
  assign bus.Out       = vld_p1 ? res_p1[0] : '0;

`ifdef LOGIC_STAGE_FLAGS_EN
  logic zero_p1 [2];
  logic par_p1  [2];

  function automatic logic is_zero(input logic [DATA_W-1:0] v);
    return (v == '0);
  endfunction

  function automatic logic odd_parity(input logic [DATA_W-1:0] v);
    return ^v;
  endfunction

  always_ff @(posedge clk) begin
    if (wr_head) begin
      zero_p1[0] <= is_zero(sel_res_p0);
      par_p1[0]  <= odd_parity(sel_res_p0);
    end else if (shift) begin
      zero_p1[0] <= zero_p1[1];
      par_p1[0]  <= par_p1[1];
    end
    if (wr_tail) begin
      zero_p1[1] <= is_zero(sel_res_p0);
      par_p1[1]  <= odd_parity(sel_res_p0);
    end
  end

  assign bus.zero   = vld_p1 && zero_p1[0];
  assign bus.parity = vld_p1 && par_p1[0];
`else
  assign bus.zero   = 1'b0;
  assign bus.parity = 1'b0;
`endif

endmodule

// File: tb/tb_logic_result_stage.sv
// tb_logic_result_stage
//   Scoreboard bench for logic_result_stage. The driver computes the
//   expected entry from operands A/B and sel with plain logic operators
//   and queues it when the model says the offer is accepted; a monitor
//   compares occupancy and the head entry every cycle and retires the
//   head when the downstream consumes it.
module tb_logic_result_stage;

  typedef struct packed {
    logic [3:0] v;
    logic       z;
    logic       p;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic_result_stage_if bus ();

  logic_result_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic mon_en    = 1'b0;
  logic after_rst = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
    exp_t e;
    case (s)
      2'b00:   e.v = a ^ b;
      2'b01:   e.v = a & b;
      2'b10:   e.v = a | b;
      default: e.v = ~(a | b);
    endcase
`ifdef LOGIC_STAGE_FLAGS_EN
    e.z = (e.v == 4'b0000);
    e.p = ^e.v;
`else
    e.z = 1'b0;
    e.p = 1'b0;
`endif
    return e;
  endfunction

  // One clock cycle of stimulus: inputs change 1 time unit after posedge.
  task automatic cycle(input logic v, input logic [3:0] a, input logic [3:0] b,
                       input logic [1:0] s, input logic ordy, input logic r);
    logic acc;
    exp_t e;
    rst           = r;
    bus.in_valid  = v;
    bus.Xor       = a ^ b;
    bus.And       = a & b;
    bus.Or        = a | b;
    bus.Nor       = ~(a | b);
    bus.sel       = s;
    bus.out_ready = ordy;
    e = model(a, b, s);
    @(negedge clk);
    acc = v && (sb.size() < 2) && !r;
    @(posedge clk);
    if (r) begin
      sb.delete();
      after_rst = 1'b1;
      mon_en    = 1'b1;
    end else if (acc) begin
      sb.push_back(e);
    end
    #1;
  endtask

  initial begin : monitor
    logic do_pop;
    forever begin
      @(negedge clk);
      do_pop = 1'b0;
      if (mon_en) begin
        check("count", 8'(bus.count), 8'(sb.size()));
        check("in_ready", 8'(bus.in_ready), 8'(sb.size() < 2));
        check("out_valid", 8'(bus.out_valid), 8'(sb.size() != 0));
        if (after_rst) begin
          check("rst_out", 8'(bus.Out), 8'h00);
          check("rst_zero", 8'(bus.zero), 8'h00);
          check("rst_parity", 8'(bus.parity), 8'h00);
          after_rst = 1'b0;
        end
        if (sb.size() != 0) begin
          check("out", 8'(bus.Out), 8'(sb[0].v));
          check("zero", 8'(bus.zero), 8'(sb[0].z));
          check("parity", 8'(bus.parity), 8'(sb[0].p));
          do_pop = bus.out_ready && !rst;
        end
      end
      @(posedge clk);
      if (do_pop && sb.size() != 0) void'(sb.pop_front());
    end
  end

  localparam logic [3:0] A = 4'b1010;
  localparam logic [3:0] B = 4'b0110;

  initial begin : driver
    // Reset
    cycle(1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b1);
    cycle(1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b1);

    // Single Xor push, consumed immediately
    cycle(1'b1, A, B, 2'b00, 1'b1, 1'b0);
    cycle(1'b0, A, B, 2'b00, 1'b1, 1'b0);
    cycle(1'b0, A, B, 2'b00, 1'b1, 1'b0);

    // Nor then And with downstream stalled, hold, then drain
    cycle(1'b1, A, B, 2'b11, 1'b0, 1'b0);
    cycle(1'b1, A, B, 2'b01, 1'b0, 1'b0);
    cycle(1'b0, A, B, 2'b00, 1'b0, 1'b0);
    cycle(1'b0, A, B, 2'b00, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, A, B, 2'b00, 1'b1, 1'b0);

    // Full queue ignores offers
    cycle(1'b1, A, B, 2'b00, 1'b0, 1'b0);
    cycle(1'b1, A, B, 2'b10, 1'b0, 1'b0);
    repeat (3) cycle(1'b1, 4'hF, 4'h3, 2'b01, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, A, B, 2'b00, 1'b1, 1'b0);

    // Simultaneous push and pop at one entry
    cycle(1'b1, A, B, 2'b00, 1'b0, 1'b0);
    cycle(1'b1, A, B, 2'b01, 1'b1, 1'b0);
    repeat (2) cycle(1'b0, A, B, 2'b00, 1'b1, 1'b0);

    // All-zero result
    cycle(1'b1, 4'hF, 4'hF, 2'b00, 1'b0, 1'b0);
    repeat (2) cycle(1'b0, A, B, 2'b00, 1'b1, 1'b0);

    // Reset while full with push and pop requested, then push again
    cycle(1'b1, A, B, 2'b00, 1'b0, 1'b0);
    cycle(1'b1, A, B, 2'b11, 1'b0, 1'b0);
    cycle(1'b1, A, B, 2'b10, 1'b1, 1'b1);
    cycle(1'b1, A, B, 2'b10, 1'b0, 1'b0);
    repeat (2) cycle(1'b0, A, B, 2'b00, 1'b1, 1'b0);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 9) < 7),
            4'($urandom), 4'($urandom), 2'($urandom),
            ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 99) < 2));
    end
    repeat (4) cycle(1'b0, A, B, 2'b00, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_result_stage.md
LOGIC_RESULT_STAGE -- requirements
Module: logic_result_stage

Interface
REQ-001 SHALL: clk  input  1  rising-edge clock; all state changes on posedge clk.
REQ-002 SHALL: rst  input  1  reset; synchronous, active-high.
REQ-003 SHALL: Xor  input  4  XOR result from the upstream logic unit.
REQ-004 SHALL: And  input  4  AND result from the upstream logic unit.
REQ-005 SHALL: Or  input  4  OR result from the upstream logic unit.
REQ-006 SHALL: Nor  input  4  NOR result from the upstream logic unit.
REQ-007 SHALL: sel  input  2  result select: 00 Xor, 01 And, 10 Or, 11 Nor.
REQ-008 SHALL: in_valid  input  1  upstream offers a result this cycle.
REQ-009 SHALL: in_ready  output  1  stage can accept; high when fewer than 2 entries held.
REQ-010 SHALL: Out  output  4  selected result at the queue head.
REQ-011 SHALL: zero  output  1  head result equals 4'b0000.
REQ-012 SHALL: parity  output  1  XOR-reduction of the head result.
REQ-013 SHALL: out_valid  output  1  head entry present.
REQ-014 SHALL: out_ready  input  1  downstream consumes head this cycle.
REQ-015 SHALL: count  output  2  entries held, 0..2.

Function
REQ-016 SHALL: push = in_valid && in_ready; pop = out_valid && out_ready; both are evaluated in the same cycle.
REQ-017 SHALL: on push, store the mux of {Xor, And, Or, Nor} by sel, as sampled on that edge, as one entry.
REQ-018 SHALL: storage is a 2-entry in-order queue with one-cycle latency; a push into an empty queue appears on Out/out_valid in the next cycle, with no combinational input-to-output path.
REQ-019 SHALL: in_ready = (count != 2), derived from registered count only and independent of out_ready.
REQ-020 SHALL: out_valid = (count != 0), with Out, zero and parity driven from the head entry.
REQ-021 SHALL: state transitions:
  - EMPTY(0) -> ONE on push.
  - ONE -> EMPTY on pop without push.
  - ONE -> TWO on push without pop.
  - ONE stays ONE on simultaneous push and pop; the new entry becomes head.
  - TWO -> ONE on pop; push is impossible because in_ready=0.
REQ-022 SHALL: in_valid while in_ready=0 has no effect; the upstream holder keeps its result.
REQ-023 SHALL: out_ready while out_valid=0 has no effect; count never underflows or exceeds 2.
REQ-024 SHALL: while out_valid=1 and out_ready=0, Out, zero and parity hold stable.
REQ-025 SHALL: the queue never drops or duplicates an entry and always preserves FIFO order.

Reset
REQ-026 SHALL: when rst=1 at posedge clk, set count=0, out_valid=0, in_ready=1, Out=4'b0000, zero=0 and parity=0.
REQ-027 SHALL: reset mid-operation discards all held entries; any push or pop in the reset cycle is ignored.
REQ-028 SHALL: in the first cycle after rst deasserts, accept a push normally.

Configuration
REQ-029 SHALL: macro LOGIC_STAGE_FLAGS_EN controls the flags.
  - Defined: compute zero and parity at push time and store them per entry alongside the 4-bit result.
  - Undefined: flag storage is omitted and zero and parity are tied to 0; all other behaviour is identical.

Verification
REQ-030 SHALL: A=1010, B=0110 (Xor=1100, And=0010, Or=1110, Nor=0001), sel=00, one push with out_ready=1 -> next cycle Out=1100, out_valid=1, zero=0, parity=0; following cycle count=0.
REQ-031 SHALL: same operands, pushes with sel=11 then sel=01 and out_ready=0 -> count=2, in_ready=0, Out=0001 held with parity=1; then out_ready=1 -> Out=0001, then 0010, then out_valid=0.
REQ-032 SHALL: count=2 with in_valid=1 held for 3 cycles -> no entry change, in_ready=0 throughout.
REQ-033 SHALL: count=1 (head 1100), simultaneous push of sel=01 (0010) and pop -> count stays 1, Out=0010 next cycle.
REQ-034 SHALL: A=B=1111, sel=00 push -> Out=0000 with zero=1 if LOGIC_STAGE_FLAGS_EN is defined, zero=0 if not.
REQ-035 SHALL: count=2, assert rst for one cycle while in_valid=1 and out_ready=1 -> count=0, out_valid=0, Out=0000; the next push is accepted and appears 1 cycle later.
